// File: rtl/draw_pkg.sv
// Shared types and helpers for the grid drawer.
// DRAW_GRID_FILL_EN adds the FILL state (background raster before the grid lines).
package draw_pkg;

`ifdef DRAW_GRID_FILL_EN
  typedef enum logic [2:0] {IDLE, FILL, HORIZ, VERT, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, HORIZ, VERT, FINISH} state_t;
`endif

  typedef logic [2:0] colour_t;

  // Board extent on each axis: CELLS pitches plus the closing line's thickness.
  function automatic int unsigned spanOf(input int unsigned cells,
                                         input int unsigned pitch,
                                         input int unsigned lineW);
    return cells * pitch + lineW;
  endfunction

endpackage

// File: rtl/draw_grid_line_scan_ctr.sv
// Three-level nested scan counter (inner, thickness, line index) with
// runtime limits, step enable and an all-at-last wrap flag.
module line_scan_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         step,
  input  logic [W-1:0] innerLast,
  input  logic [W-1:0] midLast,
  input  logic [W-1:0] outerLast,
  output logic [W-1:0] inner,
  output logic [W-1:0] mid,
  output logic [W-1:0] outer,
  output logic [W-1:0] nextInner_c,
  output logic [W-1:0] nextMid_c,
  output logic [W-1:0] nextOuter_c,
  output logic         wrap_c
);

  logic innerEnd;
  logic midEnd;
  logic outerEnd;

  // Value the counters take on the next step; everything returns to 0 on wrap.
  always_comb begin
    innerEnd    = (inner == innerLast);
    midEnd      = (mid == midLast);
    outerEnd    = (outer == outerLast);
    nextInner_c = innerEnd ? '0 : inner + W'(1);
    nextMid_c   = mid;
    nextOuter_c = outer;
    if (innerEnd) begin
      nextMid_c = midEnd ? '0 : mid + W'(1);
      if (midEnd) begin
        nextOuter_c = outerEnd ? '0 : outer + W'(1);
      end
    end
    wrap_c = innerEnd && midEnd && outerEnd;
  end

  // Counter registers advance only on step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inner <= '0;
      mid   <= '0;
      outer <= '0;
    end else if (step) begin
      inner <= nextInner_c;
      mid   <= nextMid_c;
      outer <= nextOuter_c;
    end
  end

endmodule

// File: rtl/draw_grid.sv
// Grid drawer: streams grid-line pixels over a valid/ready pixel interface.
// Optional macro DRAW_GRID_FILL_EN: raster-fill the board with BG_COLOUR first.
module draw_grid
  import draw_pkg::*;
#(
  parameter int unsigned CELLS     = 8,
  parameter int unsigned PITCH     = 13,
  parameter int unsigned LINE_W    = 2,
  parameter int unsigned X0        = 27,
  parameter int unsigned Y0        = 10,
  parameter int unsigned COORD_W   = 8,
  parameter colour_t     BG_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         colour_in,
  input  logic               plot_ready,
  output logic               plot_valid,
  output logic [COORD_W-1:0] plot_x,
  output logic [COORD_W-1:0] plot_y,
  output logic [2:0]         plot_colour,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SPAN  = spanOf(CELLS, PITCH, LINE_W);
  localparam int unsigned CNT_W = $clog2(SPAN);
  localparam logic [CNT_W-1:0] SPAN_LAST  = CNT_W'(SPAN - 1);
  localparam logic [CNT_W-1:0] LW_LAST    = CNT_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] CELLS_LAST = CNT_W'(CELLS);

  state_t  state;
  state_t  nextState;
  colour_t colourReg;
  colour_t colourSel;
  logic    advance;
  logic    wrap;

  logic [CNT_W-1:0] inner, mid, outer;
  logic [CNT_W-1:0] nInner, nMid, nOuter;
  logic [CNT_W-1:0] innerLast, midLast, outerLast;
  logic [CNT_W-1:0] iSel, mSel, oSel;

  logic               validNext;
  logic               busyNext;
  logic               doneNext;
  logic [COORD_W-1:0] xNext;
  logic [COORD_W-1:0] yNext;
  colour_t            colourNext;

  assign advance = plot_valid && plot_ready;

  line_scan_ctr #(.W(CNT_W)) scanCtr (
    .clk         (clk),
    .resetn      (resetn),
    .step        (advance),
    .innerLast   (innerLast),
    .midLast     (midLast),
    .outerLast   (outerLast),
    .inner       (inner),
    .mid         (mid),
    .outer       (outer),
    .nextInner_c (nInner),
    .nextMid_c   (nMid),
    .nextOuter_c (nOuter),
    .wrap_c      (wrap)
  );

  // Scan limits: lines use (span, thickness, line index); fill uses (x, -, y).
  always_comb begin
    innerLast = SPAN_LAST;
    midLast   = LW_LAST;
    outerLast = CELLS_LAST;
`ifdef DRAW_GRID_FILL_EN
    if (state == FILL) begin
      midLast   = '0;
      outerLast = SPAN_LAST;
    end
`endif
  end

  // State register, colour latch and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      colourReg   <= '0;
      plot_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      plot_x      <= COORD_W'(X0);
      plot_y      <= COORD_W'(Y0);
      plot_colour <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        colourReg <= colour_in;
      end
      plot_valid  <= validNext;
      busy        <= busyNext;
      done        <= doneNext;
      plot_x      <= xNext;
      plot_y      <= yNext;
      plot_colour <= colourNext;
    end
  end

  // Next-state: each drawing phase ends on the handshake of its last pixel.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DRAW_GRID_FILL_EN
          nextState = FILL;
`else
          nextState = HORIZ;
`endif
        end
      end
`ifdef DRAW_GRID_FILL_EN
      FILL:   if (advance && wrap) nextState = HORIZ;
`endif
      HORIZ:  if (advance && wrap) nextState = VERT;
      VERT:   if (advance && wrap) nextState = FINISH;
      FINISH: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output values for the coming cycle, from the counters as they will stand.
  always_comb begin
    iSel       = advance ? nInner : inner;
    mSel       = advance ? nMid   : mid;
    oSel       = advance ? nOuter : outer;
    colourSel  = (state == IDLE) ? colour_in : colourReg;
    validNext  = 1'b0;
    busyNext   = 1'b0;
    doneNext   = 1'b0;
    xNext      = COORD_W'(X0 + 32'(iSel));
    yNext      = COORD_W'(Y0 + 32'(oSel) * PITCH + 32'(mSel));
    colourNext = BG_COLOUR;
    case (nextState)
`ifdef DRAW_GRID_FILL_EN
      FILL: begin
        validNext = 1'b1;
        busyNext  = 1'b1;
        yNext     = COORD_W'(Y0 + 32'(oSel));
      end
`endif
      HORIZ: begin
        validNext  = 1'b1;
        busyNext   = 1'b1;
        colourNext = colourSel;
      end
      VERT: begin
        validNext  = 1'b1;
        busyNext   = 1'b1;
        xNext      = COORD_W'(X0 + 32'(oSel) * PITCH + 32'(mSel));
        yNext      = COORD_W'(Y0 + 32'(iSel));
        colourNext = colourSel;
      end
      FINISH:  doneNext = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_grid.sv
// Directed/randomised bench for draw_grid: default instance and a small
// CELLS=4/PITCH=10/LINE_W=1 instance, checked against a pixel-list model.
module tb_draw_grid;

  localparam int unsigned X0 = 27;
  localparam int unsigned Y0 = 10;
`ifdef DRAW_GRID_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       startA, readyA, validA, busyA, doneA;
  logic [2:0] colInA, colA;
  logic [7:0] xA, yA;
  logic       startB, readyB, validB, busyB, doneB;
  logic [2:0] colInB, colB;
  logic [7:0] xB, yB;

  draw_grid dutA (
    .clk(clk), .resetn(resetn), .start(startA), .colour_in(colInA),
    .plot_ready(readyA), .plot_valid(validA), .plot_x(xA), .plot_y(yA),
    .plot_colour(colA), .busy(busyA), .done(doneA)
  );

  draw_grid #(.CELLS(4), .PITCH(10), .LINE_W(1)) dutB (
    .clk(clk), .resetn(resetn), .start(startB), .colour_in(colInB),
    .plot_ready(readyB), .plot_valid(validB), .plot_x(xB), .plot_y(yB),
    .plot_colour(colB), .busy(busyB), .done(doneB)
  );

  int checks   = 0;
  int failures = 0;
  logic [18:0] expQ[$];
  int fillN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel stream {x, y, colour}, built straight from the drawing rules.
  task automatic buildModel(input int cells, input int pitch, input int lw, input logic [2:0] col);
    int span;
    span = cells * pitch + lw;
    expQ.delete();
    fillN = 0;
    if (FILL_ON) begin
      for (int y = 0; y < span; y++)
        for (int x = 0; x < span; x++)
          expQ.push_back({8'(X0 + x), 8'(Y0 + y), 3'b000});
      fillN = span * span;
    end
    for (int k = 0; k <= cells; k++)
      for (int r = 0; r < lw; r++)
        for (int x = 0; x < span; x++)
          expQ.push_back({8'(X0 + x), 8'(Y0 + k * pitch + r), col});
    for (int k = 0; k <= cells; k++)
      for (int c = 0; c < lw; c++)
        for (int y = 0; y < span; y++)
          expQ.push_back({8'(X0 + k * pitch + c), 8'(Y0 + y), col});
  endtask

  task automatic runDraw(input bit useB, input bit randReady, input bit rePulse,
                         input int abortAt, input logic [2:0] col,
                         output int got, output int doneCyc,
                         output logic [18:0] px0, output logic [18:0] pxLastH,
                         output logic [18:0] pxFirstV, output logic [18:0] pxLast);
    int n, hEnd, rp, budget;
    bit stalled, seenDone, anyDone;
    logic [19:0] prev;
    logic v, b, d, r;
    logic [7:0] x, y;
    logic [2:0] c;
    n = expQ.size();
    hEnd = fillN + (n - fillN) / 2;
    rp = int'($urandom_range(5, 300));
    budget = 4 * n + 200;
    stalled = 1'b0; seenDone = 1'b0; prev = '0;
    got = 0; doneCyc = -1;
    px0 = '0; pxLastH = '0; pxFirstV = '0; pxLast = '0;
    @(negedge clk);
    if (useB) begin startB = 1'b1; colInB = col; readyB = 1'b1; end
    else begin startA = 1'b1; colInA = col; readyA = 1'b1; end
    @(negedge clk);
    startA = 1'b0; startB = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      r = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      v = useB ? validB : validA;
      b = useB ? busyB : busyA;
      d = useB ? doneB : doneA;
      x = useB ? xB : xA;
      y = useB ? yB : yA;
      c = useB ? colB : colA;
      if (useB) readyB = r; else readyA = r;
      if (rePulse && cyc == rp) begin
        if (useB) begin startB = 1'b1; colInB = 3'b010; end
        else begin startA = 1'b1; colInA = 3'b010; end
      end else if (rePulse && cyc == rp + 1) begin
        startA = 1'b0; startB = 1'b0;
      end
      if (cyc == 0) begin
        chk("first_valid", 32'(v), 32'd1);
        chk("first_busy", 32'(b), 32'd1);
      end
      if (stalled) chk("stall_hold", 32'({v, x, y, c}), 32'(prev));
      if (d) begin
        seenDone = 1'b1;
        doneCyc = cyc;
        chk("done_valid", 32'(v), 32'd0);
        chk("done_busy", 32'(b), 32'd0);
        break;
      end
      if (v && r) begin
        if (got < n) chk("pixel", 32'({x, y, c}), 32'(expQ[got]));
        else chk("extra_pixel", 32'(got), 32'(n));
        if (got == 0) px0 = {x, y, c};
        if (got == hEnd - 1) pxLastH = {x, y, c};
        if (got == hEnd) pxFirstV = {x, y, c};
        if (got == n - 1) pxLast = {x, y, c};
        got++;
      end
      stalled = v && !r;
      prev = {v, x, y, c};
      if (abortAt > 0 && got == abortAt) begin
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(useB ? validB : validA), 32'd0);
        chk("abort_busy", 32'(useB ? busyB : busyA), 32'd0);
        chk("abort_x", 32'(useB ? xB : xA), 32'(X0));
        resetn = 1'b1;
        anyDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          anyDone |= (useB ? doneB : doneA);
        end
        chk("abort_no_done", 32'(anyDone), 32'd0);
        return;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seenDone), 32'd1);
    if (seenDone) begin
      @(negedge clk);
      chk("idle_after_done", 32'(useB ? busyB : busyA), 32'd0);
    end
  endtask

  int got, doneCyc, lineTotal, n;
  logic [18:0] p0, pLH, pFV, pL;
  logic [2:0] colRand;

  initial begin
    resetn = 1'b0;
    startA = 1'b0; readyA = 1'b0; colInA = 3'b000;
    startB = 1'b0; readyB = 1'b0; colInB = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(validA), 32'd0);
    chk("rst_busy", 32'(busyA), 32'd0);
    chk("rst_done", 32'(doneA), 32'd0);
    chk("rst_xy", 32'({xA, yA}), 32'h1B0A);
    chk("rst_colour", 32'(colA), 32'd0);
    chk("rst_b_xy", 32'({validB, xB, yB}), 32'h01B0A);
    resetn = 1'b1;

    // Default grid, sink always ready.
    buildModel(8, 13, 2, 3'b101);
    n = expQ.size();
    lineTotal = 3816;
    runDraw(1'b0, 1'b0, 1'b0, -1, 3'b101, got, doneCyc, p0, pLH, pFV, pL);
    chk("count_ready", 32'(got), 32'(lineTotal + (FILL_ON ? 11236 : 0)));
    chk("done_latency", 32'(doneCyc), 32'(n));
    chk("first_px", 32'(p0[18:3]), 32'h1B0A);
    chk("last_horiz", 32'({pLH[18:3]}), 32'h8473);
    chk("first_vert", 32'(pFV), 32'({8'd27, 8'd10, 3'b101}));

    // Random backpressure, start re-pulsed with another colour mid-draw.
    runDraw(1'b0, 1'b1, 1'b1, -1, 3'b101, got, doneCyc, p0, pLH, pFV, pL);
    chk("count_random", 32'(got), 32'(n));

    // Reset at pixel 1000, then a fresh full draw.
    runDraw(1'b0, 1'b1, 1'b0, 1000, 3'b101, got, doneCyc, p0, pLH, pFV, pL);
    chk("abort_count", 32'(got), 32'd1000);
    runDraw(1'b0, 1'b0, 1'b0, -1, 3'b101, got, doneCyc, p0, pLH, pFV, pL);
    chk("count_after_abort", 32'(got), 32'(n));

    // Small grid with a random colour.
    colRand = 3'($urandom_range(0, 7));
    buildModel(4, 10, 1, colRand);
    runDraw(1'b1, 1'b1, 1'b0, -1, colRand, got, doneCyc, p0, pLH, pFV, pL);
    chk("small_lines", 32'(got - fillN), 32'd410);
    chk("small_last", 32'(pL), 32'({8'd67, 8'd50, colRand}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
